pq_share_arbiter: RTL and testbench

- Round-robin arbiter that shares one registered p/q output stage (p follows the input bit, q follows its inverse) among NUM_REQ requesters.
- Each requester presents a data bit plus req/lock. The arbiter grants one requester at a time and caps locked bursts at MAX_BURST transfers.
- Sits between the requesting sources and the downstream consumers of p/q.

---
 rtl/pq_share_arbiter.sv | 140 ++++++++++++++
 tb/tb_pq_share_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pq_share_arbiter.sv
// Round-robin arbiter sharing one registered p/q output stage among NUM_REQ requesters.
// Locked grants are capped at MAX_BURST transfers; release re-arbitrates on the same edge.
module pq_share_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_BURST = 4,
    localparam int unsigned IDW      = $clog2(NUM_REQ),
    localparam int unsigned CW       = $clog2(MAX_BURST + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] lock,
    input  logic [NUM_REQ-1:0] a_in,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [IDW-1:0]     gnt_id,
    output logic               p,
    output logic               q,
    output logic [CW-1:0]      burst_cnt
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state, state_nxt;
    logic [IDW-1:0]     ptr, ptr_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [IDW-1:0]     gnt_id_nxt;
    logic               p_nxt, q_nxt;
    logic [CW-1:0]      burst_nxt;

    logic               xfer, rel;
    logic [IDW-1:0]     scan_start;
    logic               win_found;
    logic [IDW-1:0]     win_id;

    // Successor index modulo NUM_REQ (NUM_REQ need not be a power of two).
    function automatic logic [IDW-1:0] succ(input logic [IDW-1:0] k);
        if (k == IDW'(NUM_REQ - 1)) begin
            return '0;
        end
        return k + IDW'(1);
    endfunction

    // First set request bit scanning start, start+1, ... with wraparound; MSB = found.
    function automatic logic [IDW:0] first_from(input logic [NUM_REQ-1:0] r,
                                                input logic [IDW-1:0]     start);
        int unsigned t;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            t = 32'(start) + i;
            if (t >= NUM_REQ) begin
                t = t - NUM_REQ;
            end
            if (r[t]) begin
                return {1'b1, IDW'(t)};
            end
        end
        return '0;
    endfunction

    // State register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            p         <= 1'b0;
            q         <= 1'b0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            gnt       <= gnt_nxt;
            gnt_valid <= |gnt_nxt;
            gnt_id    <= gnt_id_nxt;
            p         <= p_nxt;
            q         <= q_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    // Next state: transfer/release decision and the arbitration scan.
    always_comb begin
        state_nxt  = state;
        xfer       = 1'b0;
        rel        = 1'b0;
        scan_start = ptr;
        if (state == GRANT) begin
            scan_start = succ(gnt_id);
            xfer       = req[gnt_id];
            rel        = !req[gnt_id] || !lock[gnt_id] ||
                         (burst_cnt + CW'(1) == CW'(MAX_BURST));
        end
        {win_found, win_id} = first_from(req, scan_start);
        case (state)
            IDLE:    if (win_found) state_nxt = GRANT;
            GRANT:   if (rel && !win_found) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output/datapath next values.
    always_comb begin
        ptr_nxt    = ptr;
        gnt_nxt    = gnt;
        gnt_id_nxt = gnt_id;
        p_nxt      = p;
        q_nxt      = q;
        burst_nxt  = burst_cnt;
        case (state)
            IDLE: begin
                if (win_found) begin
                    gnt_nxt    = NUM_REQ'(1) << win_id;
                    gnt_id_nxt = win_id;
                    burst_nxt  = '0;
                end
            end
            GRANT: begin
                if (xfer) begin
                    p_nxt     = a_in[gnt_id];
                    q_nxt     = ~a_in[gnt_id];
                    burst_nxt = burst_cnt + CW'(1);
                end
                if (rel) begin
                    ptr_nxt   = succ(gnt_id);
                    burst_nxt = '0;
                    if (win_found) begin
                        gnt_nxt    = NUM_REQ'(1) << win_id;
                        gnt_id_nxt = win_id;
                    end else begin
                        gnt_nxt = '0;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pq_share_arbiter.sv
// Bench for pq_share_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_pq_share_arbiter;

    localparam int N  = 4;
    localparam int MB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, lock, a_in;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic       p, q;
    logic [2:0] burst_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    // Behavioural model: current owner (-1 = nobody), priority start, transfer count.
    int   m_owner, m_last, m_ptr, m_bcnt;
    logic m_p, m_q;

    pq_share_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .a_in(a_in),
        .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id),
        .p(p), .q(q), .burst_cnt(burst_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int scan(input int s, input logic [3:0] r);
        for (int i = 0; i < N; i++) begin
            if (r[(s + i) % N]) return (s + i) % N;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_owner = -1; m_last = 0; m_ptr = 0; m_bcnt = 0; m_p = 1'b0; m_q = 1'b0;
    endfunction

    // Effect of one rising edge given the inputs presented before it.
    function automatic void model_edge();
        int  w, k;
        bit  done;
        if (m_owner < 0) begin
            w = scan(m_ptr, req);
            if (w >= 0) begin m_owner = w; m_last = w; m_bcnt = 0; end
        end else begin
            k = m_owner;
            done = 1'b1;
            if (req[k]) begin
                m_p = a_in[k];
                m_q = !a_in[k];
                m_bcnt++;
                done = !lock[k] || (m_bcnt == MB);
            end
            if (done) begin
                m_ptr  = (k + 1) % N;
                m_bcnt = 0;
                w = scan(m_ptr, req);
                if (w >= 0) begin m_owner = w; m_last = w; end
                else m_owner = -1;
            end
        end
    endfunction

    // Single compare point: all DUT outputs against the model.
    task automatic check_model();
        chk("gnt",       int'(gnt),       (m_owner < 0) ? 0 : (1 << m_owner));
        chk("gnt_valid", int'(gnt_valid), (m_owner < 0) ? 0 : 1);
        chk("gnt_id",    int'(gnt_id),    m_last);
        chk("p",         int'(p),         int'(m_p));
        chk("q",         int'(q),         int'(m_q));
        chk("burst_cnt", int'(burst_cnt), m_bcnt);
        chk("onehot",    ($countones(gnt) <= 1) ? 1 : 0, 1);
    endtask

    task automatic cycle(input logic [3:0] r, input logic [3:0] l, input logic [3:0] a);
        req = r; lock = l; a_in = a;
        model_edge();
        @(posedge clk); #1;
        check_model();
    endtask

    // Asynchronous reset pulse placed between edges; outputs must clear without a clock.
    task automatic mid_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_model();
        chk("async_rst_gnt", int'(gnt), 0);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; lock = '0; a_in = '0;
        model_reset();
        @(posedge clk); #1;
        check_model();
        chk("reset_p", int'(p), 0);
        rst = 1'b0;

        // Single requester: grant, transfer, back-to-back regrant to itself.
        cycle(4'b0001, 4'b0000, 4'b0001);
        chk("s1_gnt_e1", int'(gnt), 1);
        cycle(4'b0001, 4'b0000, 4'b0001);
        chk("s1_p_e2", int'(p), 1);
        chk("s1_q_e2", int'(q), 0);
        chk("s1_gnt_e2", int'(gnt), 1);

        // Fairness rotation with everyone requesting and no lock.
        mid_reset();
        cycle(4'b1111, 4'b0000, 4'b1010);
        chk("rr_first", int'(gnt), 1);
        for (int i = 1; i < 8; i++) begin
            cycle(4'b1111, 4'b0000, 4'b1010);
            chk("rr_seq", int'(gnt), 1 << (i % N));
        end

        // Locked burst capped at MAX_BURST, then hand-off to requester 1.
        mid_reset();
        cycle(4'b0011, 4'b0001, 4'b0000);
        chk("lk_cnt0", int'(burst_cnt), 0);
        for (int i = 1; i < MB; i++) begin
            cycle(4'b0011, 4'b0001, 4'b0001);
            chk("lk_cnt", int'(burst_cnt), i);
            chk("lk_gnt", int'(gnt), 1);
        end
        cycle(4'b0011, 4'b0001, 4'b0001);
        chk("lk_handoff", int'(gnt), 2);
        chk("lk_cnt_clr", int'(burst_cnt), 0);

        // Grantee 2 drops its request: no transfer, scan wraps from 3 to 1.
        mid_reset();
        cycle(4'b0100, 4'b0100, 4'b0000);
        cycle(4'b0110, 4'b0100, 4'b0100);
        chk("drop_pre_p", int'(p), 1);
        cycle(4'b0010, 4'b0000, 4'b0000);
        chk("drop_gnt", int'(gnt), 2);
        chk("drop_p_hold", int'(p), 1);

        // Lone requester goes quiet: idle, gnt_id holds, p/q hold.
        cycle(4'b0000, 4'b0000, 4'b0000);
        chk("idle_valid", int'(gnt_valid), 0);
        chk("idle_id", int'(gnt_id), 1);
        chk("idle_q", int'(q), 0);

        // Reset mid-burst, then first grant after reset.
        cycle(4'b0001, 4'b0001, 4'b0001);
        cycle(4'b0001, 4'b0001, 4'b0001);
        mid_reset();
        cycle(4'b1000, 4'b0000, 4'b0000);
        chk("post_rst_gnt", int'(gnt), 8);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] r, l, a;
            r = 4'($urandom) & 4'($urandom | 32'h5);
            l = 4'($urandom);
            a = 4'($urandom);
            if ($urandom_range(0, 199) == 0) mid_reset();
            cycle(r, l, a);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
